// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W : width of one add slice (the fa4 operand width)
//   state_e  : controller state encoding
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_serial_adder_fa4.sv
// fa4: 4-bit combinational full-adder slice.
//   A, B : 4-bit addends
//   Cin  : carry in
//   Sum  : 4-bit sum
//   Cout : carry out
module fa4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule : fa4

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder built from one fa4 slice, processing one nibble per
// clock, LSB nibble first, with the carry registered between cycles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (A_in, B_in, Cin_in)
//   out_valid/out_ready : result handshake (Sum_out, Cout_out)
//   busy                : high while nibbles are being added
// All outputs come from registers or from the state register alone.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             Cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum_out,
    output logic             Cout_out,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [NIBBLE_W-1:0] fa_sum;
    logic                fa_cout;
    logic [WIDTH-1:0]    result_shifted;

    fa4 u_fa4 (
        .A    (a_q[NIBBLE_W-1:0]),
        .B    (b_q[NIBBLE_W-1:0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // New sum nibble enters at the top so that after NIB shifts the first nibble sits at the LSB.
    always_comb begin
        result_shifted = result_q >> NIBBLE_W;
        result_shifted[WIDTH-1 -: NIBBLE_W] = fa_sum;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A_in;
                    b_d     = B_in;
                    carry_d = Cin_in;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                carry_d  = fa_cout;
                result_d = result_shifted;
                a_d      = a_q >> NIBBLE_W;
                b_d      = b_q >> NIBBLE_W;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NIB - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_ADD);
    assign out_valid = (state_q == ST_DONE);
    assign Sum_out   = result_q;
    assign Cout_out  = carry_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16. Expected results are pushed when an
// operand set is accepted; a negedge monitor compares and pops on each output handshake.
module tb_nibble_serial_adder;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A_in;
    logic [W-1:0] B_in;
    logic         Cin_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum_out;
    logic         Cout_out;
    logic         busy;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_in      (A_in),
        .B_in      (B_in),
        .Cin_in    (Cin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum_out   (Sum_out),
        .Cout_out  (Cout_out),
        .busy      (busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: result must match queue head on every valid cycle (covers stall stability).
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("in_ready_low_in_done", {31'b0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum 0x%0h with empty scoreboard at %0t",
                         Sum_out, $time);
            end else begin
                chk("sum", {16'b0, Sum_out}, {16'b0, exp_q[0].s});
                chk("cout", {31'b0, Cout_out}, {31'b0, exp_q[0].c});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present operands and hold until accepted; returns at accept edge + 1.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit push);
        logic [W:0] full;
        bit         done;
        A_in     = a;
        B_in     = b;
        Cin_in   = cin;
        in_valid = 1;
        done     = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 at %0t", $time);
        end else if (push) begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            exp_q.push_back('{s: full[W-1:0], c: full[W]});
        end
    endtask

    // Called at accept edge + 1 with out_ready high.
    task automatic check_timing();
        chk("busy_t0", {31'b0, busy}, 32'd1);
        chk("valid_t0", {31'b0, out_valid}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("busy_mid", {31'b0, busy}, 32'd1);
            chk("valid_mid", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("valid_at_t4", {31'b0, out_valid}, 32'd1);
        chk("busy_at_t4", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("idle_at_t5", {31'b0, in_ready}, 32'd1);
        chk("valid_off_t5", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst_n     = 0;
        in_valid  = 0;
        A_in      = '0;
        B_in      = '0;
        Cin_in    = 0;
        out_ready = 1;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_sum", {16'b0, Sum_out}, 32'd0);
        chk("rst_cout", {31'b0, Cout_out}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Simple add with exact latency check.
        send(16'h0006, 16'h0004, 1'b0, 1);
        check_timing();

        // Full ripple; busy exactly 4 cycles.
        send(16'hFFFF, 16'h0001, 1'b0, 1);
        check_timing();

        send(16'h8008, 16'h9009, 1'b1, 1);
        wait_drain();

        // Back-pressure with a second request waiting during ADD/DONE.
        out_ready = 0;
        send(16'hAAAA, 16'hBBBB, 1'b0, 1);
        fork
            begin
                for (int i = 0; i < 20 && !out_valid; i++) begin
                    @(posedge clk);
                    #1;
                end
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1;
            end
            send(16'h1111, 16'h2222, 1'b0, 1);
        join
        wait_drain();

        // Reset during the second ADD cycle discards the operation.
        send(16'h1234, 16'h4321, 1'b0, 0);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_sum", {16'b0, Sum_out}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        send(16'h0F0F, 16'h00F1, 1'b0, 1);
        wait_drain();

        // Model-checked pseudo-random ops with random back-pressure.
        rand_ready = 1;
        for (int n = 0; n < 60; n++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1);
        end
        wait_drain();
        rand_ready = 0;
        out_ready  = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle adder of WIDTH-bit operands using a single fa4 4-bit slice, one nibble per clock, LSB nibble first.
- The carry is registered between cycles, so a wide add costs WIDTH/4 cycles of one fa4 instead of a wide combinational adder.
- Sits directly upstream of and around fa4: it sequences operand nibbles into the slice and collects Sum/Cout from it.
- Valid/ready handshake on both the input and the output side.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of add cycles; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept operands
- A_in  input  WIDTH  operand A
- B_in  input  WIDTH  operand B
- Cin_in  input  1  carry-in to the LSB nibble
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- Sum_out  output  WIDTH  A_in+B_in+Cin_in modulo 2^WIDTH
- Cout_out  output  1  carry out of the MSB nibble
- busy  output  1  high in ADD state

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, nibble counter=0, carry reg=0, operand/result regs=0.
  - Reset values: in_ready=1, out_valid=0, busy=0, Sum_out=0, Cout_out=0.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge T, latch A_in, B_in into shift regs, carry<=Cin_in, counter<=0, go to ADD.
  - ADD: in_ready=0, busy=1. Each edge feeds the low nibbles of the A/B shift regs plus the carry reg to fa4, then:
    - carry<=fa4 Cout;
    - result reg shifts right 4 and takes fa4 Sum into its top nibble;
    - A/B shift right 4;
    - counter++.
    - When counter==NIB-1 at the edge, go to DONE.
  - DONE: out_valid=1, Sum_out=result reg, Cout_out=carry reg; values stay stable until the handshake. On out_valid&&out_ready, go to IDLE.
- Latency: out_valid rises exactly NIB cycles after the accept edge (NIB=4 gives edge T+4). Throughput is one op per NIB+2 cycles minimum.
- Sum_out and Cout_out are meaningful only while out_valid=1. In other states they hold the last result and the bench must not check them.
- in_valid while not in IDLE: ignored, operands not sampled; upstream must hold them.
- Back-pressure: out_ready low in DONE holds the result indefinitely; in_ready stays 0.
- Counter wrap: the counter is reset to 0 on each accept and never wraps within an op.
- Carry chain: the carry reg is the only inter-nibble link. Full-ripple cases such as 0xFFFF+1 must propagate over NIB cycles.
- Reset mid-operation: asynchronous abort to IDLE with reset values; the partial result is discarded and no out_valid pulse is produced.
- in_valid asserted in the same cycle as rst_n deassertion: may be accepted at the first rising edge after release. Benches must not rely on that edge.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2;
  - NIBBLE_W=4.
- One sub-module: the existing fa4 (A, B, Cin, Sum, Cout) instantiated once as the combinational slice. No new adder logic in this block.
- Counter width is $clog2(NIB), minimum 1.

Test Plan:
- WIDTH=16, A=0x0006, B=0x0004, Cin=0, out_ready=1 -> out_valid at accept+4, Sum_out=0x000A, Cout_out=0, back to IDLE the next cycle.
- A=0xFFFF, B=0x0001, Cin=0 -> Sum_out=0x0000, Cout_out=1; busy high for exactly 4 cycles.
- A=0x8008, B=0x9009, Cin=1 -> Sum_out=0x1012, Cout_out=1.
- A=0xAAAA, B=0xBBBB, Cin=0 with out_ready low 3 cycles; second in_valid with A=0x1111 during ADD/DONE:
  - first result Sum_out=0x6665, Cout_out=1, stable for all stalled cycles;
  - second operands are not accepted until IDLE, then give 0x1111+B.
- rst_n pulsed low during the 2nd ADD cycle of A=0x1234, B=0x4321 -> out_valid=0, Sum_out=0, in_ready=1 immediately.
  - Next op A=0x0F0F, B=0x00F1, Cin=0 -> Sum_out=0x1000, Cout_out=0.
- Randomised 200 ops at WIDTH=8 and WIDTH=16 with random out_ready -> every result equals (A+B+Cin) against a reference model, in order, none lost or duplicated.
